seven_segment_scan_controller: RTL

Time-multiplexes a 16-bit display value (two bytes, four hex nibbles) onto a 4-digit common-anode 7-segment display through one shared nibble decoder. It sits between the vending datapath (balance/price registers) and the board display pins. It provides tear-free value updates, inter-digit dead time, per-digit blank/blink and leading-zero suppression.

---
 rtl/seven_segment_scan_controller_pkg.sv | 40 ++++
 rtl/seven_segment_scan_controller_hex_nibble_decoder.sv | 31 +++
 rtl/seven_segment_scan_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scan controller.
// Segment patterns are active-low {g,f,e,d,c,b,a} for a common-anode display.
package seven_segment_scan_controller_pkg;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned VALUE_W    = NIBBLE_W * NUM_DIGITS;

    typedef enum logic {
        ST_DEAD  = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Registered pin drive: digit enables and segment pattern travel together.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] digit_sel_n;
        logic [SEG_W-1:0]      segment_n;
    } disp_drive_t;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seven_segment_scan_controller_hex_nibble_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_nibble_decoder
    import seven_segment_scan_controller_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [SEG_W-1:0]    seg_n_c_o
);

    always_comb begin
        seg_n_c_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_n_c_o = SEG_0;
            4'h1: seg_n_c_o = SEG_1;
            4'h2: seg_n_c_o = SEG_2;
            4'h3: seg_n_c_o = SEG_3;
            4'h4: seg_n_c_o = SEG_4;
            4'h5: seg_n_c_o = SEG_5;
            4'h6: seg_n_c_o = SEG_6;
            4'h7: seg_n_c_o = SEG_7;
            4'h8: seg_n_c_o = SEG_8;
            4'h9: seg_n_c_o = SEG_9;
            4'hA: seg_n_c_o = SEG_A;
            4'hB: seg_n_c_o = SEG_B;
            4'hC: seg_n_c_o = SEG_C;
            4'hD: seg_n_c_o = SEG_D;
            4'hE: seg_n_c_o = SEG_E;
            4'hF: seg_n_c_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Scans a 16-bit value onto a 4-digit common-anode display with dead time,
// frame-synchronous value updates, blank/blink masks and leading-zero suppression.
module seven_segment_scan_controller
    import seven_segment_scan_controller_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS  = 50000,
    parameter int unsigned DEAD_TICKS   = 500,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic                  value_load,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic                  zero_suppress,
    output logic [NUM_DIGITS-1:0] digit_select_n,
    output logic [SEG_W-1:0]      segment_n,
    output logic                  frame_done,
    output logic                  value_pending
);

    localparam int unsigned PRESC_W = $clog2(DIGIT_TICKS);
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRESC_W-1:0] DEAD_LAST  = PRESC_W'(DEAD_TICKS - 1);
    localparam logic [PRESC_W-1:0] SLOT_LAST  = PRESC_W'(DIGIT_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e          state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [VALUE_W-1:0]   shadow_q, shadow_d;
    logic [VALUE_W-1:0]   active_q, active_d;
    logic                 pending_q, pending_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_on_q, blink_on_d;
    logic                 frame_done_q;
    disp_drive_t          drive_q, drive_d;
    logic                 boundary_c;
    logic [VALUE_W-1:0]   upper_c;
    logic [NIBBLE_W-1:0]  nibble_c;
    logic                 blank_c;
    logic [SEG_W-1:0]     seg_dec_c;

    // Slot sequencing, frame-synchronous value transfer and blink phase.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q + PRESC_W'(1);
        idx_d       = idx_q;
        boundary_c  = 1'b0;
        shadow_d    = shadow_q;
        active_d    = active_q;
        pending_d   = pending_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;

        case (state_q)
            ST_DEAD: begin
                if (presc_q == DEAD_LAST) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (presc_q == SLOT_LAST) begin
                    state_d    = ST_DEAD;
                    presc_d    = '0;
                    idx_d      = idx_q + IDX_W'(1);
                    boundary_c = (idx_q == IDX_LAST);
                end
            end
        endcase

        if (value_load) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end
        // A load landing on the boundary bypasses the shadow and never shows as pending.
        if (boundary_c) begin
            active_d  = value_load ? value_in : shadow_q;
            pending_d = 1'b0;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Content of the digit about to be driven; shifting out lower nibbles exposes i..3.
    assign upper_c  = active_q >> {idx_d, 2'b00};
    assign nibble_c = NIBBLE_W'(upper_c);
    assign blank_c  = blank_mask[idx_d]
                   || (blink_mask[idx_d] && !blink_on_q)
                   || (zero_suppress && (idx_d != '0) && (upper_c == '0));

    hex_nibble_decoder u_decoder (
        .nibble_i  (nibble_c),
        .seg_n_c_o (seg_dec_c)
    );

    always_comb begin
        drive_d.digit_sel_n = '1;
        drive_d.segment_n   = SEG_BLANK;
        if (state_d == ST_DRIVE) begin
            drive_d.digit_sel_n = ~(NUM_DIGITS'(1) << idx_d);
            if (!blank_c) drive_d.segment_n = seg_dec_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_DEAD;
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            frame_done_q <= 1'b0;
            drive_q      <= '{digit_sel_n: '1, segment_n: SEG_BLANK};
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            frame_done_q <= boundary_c;
            drive_q      <= drive_d;
        end
    end

    assign digit_select_n = drive_q.digit_sel_n;
    assign segment_n      = drive_q.segment_n;
    assign frame_done     = frame_done_q;
    assign value_pending  = pending_q;

endmodule
